// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 operate-instruction sequencer: opcodes, field positions,
// FSM state encoding and the legality check used at accept time.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned DR_LSB  = 9;
  localparam int unsigned SR1_LSB = 6;
  localparam int unsigned IMM_BIT = 5;
  localparam int unsigned SR2_LSB = 0;

  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  // NOT is only a valid encoding when its low six bits are all ones.
  function automatic logic is_legal(input logic [15:0] ins);
    logic [3:0] op;
    op = ins[OP_LSB +: 4];
    return (op == OP_ADD) || (op == OP_AND) || ((op == OP_NOT) && (ins[5:0] == 6'h3f));
  endfunction

endpackage

// File: rtl/lc3_alu.sv
// Combinational ADD/AND/NOT datapath; the second operand is either SR2 or the
// sign-extended 5-bit immediate.
module lc3_alu
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic              imm,
  input  logic [4:0]        imm5,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] operand;

  always_comb begin
    operand = imm ? {{(DATA_W - 5){imm5[4]}}, imm5} : b;
    result  = '0;
    case (op)
      OP_ADD:  result = a + operand;
      OP_AND:  result = a & operand;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lc3_regop_sequencer.sv
// Register-file initiator that runs one LC-3 ADD/AND/NOT per handshake through
// IDLE -> READ -> EXEC -> WB, with every output taken straight from a flop.
module lc3_regop_sequencer
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DATA_W-1:0]     instr,
  output logic                  rf_ld,
  output logic [REG_ADDR_W-1:0] rf_dr,
  output logic [DATA_W-1:0]     rf_dr_in,
  output logic [REG_ADDR_W-1:0] rf_sr1,
  output logic [REG_ADDR_W-1:0] rf_sr2,
  input  logic [DATA_W-1:0]     rf_sr1_out,
  input  logic [DATA_W-1:0]     rf_sr2_out,
  output logic                  done,
  output logic                  illegal,
  output logic [2:0]            nzp
);

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic                  imm_q, imm_d;
  logic [4:0]            imm5_q, imm5_d;
  logic                  ready_q, ready_d;
  logic                  ld_q, ld_d;
  logic                  done_q, done_d;
  logic                  illegal_q, illegal_d;
  logic [REG_ADDR_W-1:0] dr_q, dr_d, sr1_q, sr1_d, sr2_q, sr2_d;
  logic [DATA_W-1:0]     dr_in_q, dr_in_d;
  logic [2:0]            nzp_q, nzp_d;
  logic [DATA_W-1:0]     alu_result;

  lc3_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op    (op_q),
    .imm   (imm_q),
    .imm5  (imm5_q),
    .a     (rf_sr1_out),
    .b     (rf_sr2_out),
    .result(alu_result)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    imm5_d    = imm5_q;
    ready_d   = 1'b0;
    ld_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    dr_d      = dr_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    dr_in_d   = dr_in_q;
    nzp_d     = nzp_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (instr_valid && ready_q) begin
          op_d      = instr[OP_LSB +: 4];
          imm_d     = instr[IMM_BIT];
          imm5_d    = instr[4:0];
          dr_d      = instr[DR_LSB +: REG_ADDR_W];
          sr1_d     = instr[SR1_LSB +: REG_ADDR_W];
          sr2_d     = instr[SR2_LSB +: REG_ADDR_W];
          illegal_d = ~is_legal(instr);
          ready_d   = 1'b0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (illegal_q) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands are sampled here, one cycle before the write-back edge.
        dr_in_d = alu_result;
        ld_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        if (dr_in_q == '0) begin
          nzp_d = 3'b010;
        end else if (dr_in_q[DATA_W-1]) begin
          nzp_d = 3'b100;
        end else begin
          nzp_d = 3'b001;
        end
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      imm_q     <= 1'b0;
      imm5_q    <= '0;
      ready_q   <= 1'b0;
      ld_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      dr_q      <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      dr_in_q   <= '0;
      nzp_q     <= NZP_RESET;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      imm5_q    <= imm5_d;
      ready_q   <= ready_d;
      ld_q      <= ld_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      dr_q      <= dr_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      dr_in_q   <= dr_in_d;
      nzp_q     <= nzp_d;
    end
  end

  assign instr_ready = ready_q;
  assign rf_ld       = ld_q;
  assign rf_dr       = dr_q;
  assign rf_dr_in    = dr_in_q;
  assign rf_sr1      = sr1_q;
  assign rf_sr2      = sr2_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign nzp         = nzp_q;

endmodule

// File: tb/tb_lc3_regop_sequencer.sv
// Bench for lc3_regop_sequencer: a behavioural 8x16 register file on the port plus an
// instruction-level reference model of the register contents and condition codes.
module tb_lc3_regop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        rf_ld;
  logic [2:0]  rf_dr;
  logic [15:0] rf_dr_in;
  logic [2:0]  rf_sr1;
  logic [2:0]  rf_sr2;
  logic [15:0] rf_sr1_out;
  logic [15:0] rf_sr2_out;
  logic        done;
  logic        illegal;
  logic [2:0]  nzp;

  always #5 clk = ~clk;

  lc3_regop_sequencer #(
    .DATA_W    (16),
    .REG_ADDR_W(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rf_ld      (rf_ld),
    .rf_dr      (rf_dr),
    .rf_dr_in   (rf_dr_in),
    .rf_sr1     (rf_sr1),
    .rf_sr2     (rf_sr2),
    .rf_sr1_out (rf_sr1_out),
    .rf_sr2_out (rf_sr2_out),
    .done       (done),
    .illegal    (illegal),
    .nzp        (nzp)
  );

  // Register file with unknown-but-defined start contents.
  logic [15:0] rf [8];
  logic        scramble;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'($urandom);
    end else if (rf_ld) begin
      rf[rf_dr] <= rf_dr_in;
    end
  end
  assign rf_sr1_out = rf[rf_sr1];
  assign rf_sr2_out = rf[rf_sr2];

  logic [15:0] mreg [8];
  logic [2:0]  mnzp;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Instruction-level semantics straight from the ISA rules.
  function automatic void model(input logic [15:0] ins, output bit legal, output logic [15:0] res);
    int op;
    int a;
    int b;
    logic [4:0] i5;
    op = int'(ins[15:12]);
    a  = int'(mreg[ins[8:6]]);
    i5 = ins[4:0];
    b  = ins[5] ? int'($signed(i5)) : int'(mreg[ins[2:0]]);
    legal = (op == 1) || (op == 5) || (op == 9 && ins[5:0] == 6'h3f);
    case (op)
      1:       res = 16'(a + b);
      5:       res = 16'(a & b);
      9:       res = 16'(~a);
      default: res = 16'h0;
    endcase
  endfunction

  function automatic logic [2:0] flags(input logic [15:0] r);
    if (r == 16'h0) return 3'b010;
    if (r > 16'h7fff) return 3'b100;
    return 3'b001;
  endfunction

  task automatic cmp_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s.R%0d", tag, i), 32'(rf[i]), 32'(mreg[i]));
  endtask

  // Issue one instruction from IDLE and check every cycle until it retires.
  task automatic run(input logic [15:0] ins, input string tag);
    bit          legal;
    logic [15:0] res;
    int          nld;
    nld = 0;
    model(ins, legal, res);
    instr       = ins;
    instr_valid = 1'b1;
    chk({tag, ".ready_c0"}, 32'(instr_ready), 1);
    tick;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    chk({tag, ".illegal_c1"}, 32'(illegal), 32'(!legal));
    chk({tag, ".ready_c1"}, 32'(instr_ready), 0);
    chk({tag, ".sr1_c1"}, 32'(rf_sr1), 32'(ins[8:6]));
    chk({tag, ".sr2_c1"}, 32'(rf_sr2), 32'(ins[2:0]));
    nld += int'(rf_ld);
    if (!legal) begin
      tick;
      chk({tag, ".ready_c2"}, 32'(instr_ready), 1);
      chk({tag, ".illegal_c2"}, 32'(illegal), 0);
      chk({tag, ".nzp_kept"}, 32'(nzp), 32'(mnzp));
      nld += int'(rf_ld);
      chk({tag, ".no_ld"}, 32'(nld), 0);
    end else begin
      tick;
      chk({tag, ".ready_c2"}, 32'(instr_ready), 0);
      chk({tag, ".ld_c2"}, 32'(rf_ld), 0);
      chk({tag, ".sr1_c2"}, 32'(rf_sr1), 32'(ins[8:6]));
      tick;
      chk({tag, ".ld_c3"}, 32'(rf_ld), 1);
      chk({tag, ".done_c3"}, 32'(done), 1);
      chk({tag, ".dr_c3"}, 32'(rf_dr), 32'(ins[11:9]));
      chk({tag, ".dr_in_c3"}, 32'(rf_dr_in), 32'(res));
      chk({tag, ".sr1_c3"}, 32'(rf_sr1), 32'(ins[8:6]));
      chk({tag, ".sr2_c3"}, 32'(rf_sr2), 32'(ins[2:0]));
      tick;
      mreg[ins[11:9]] = res;
      mnzp = flags(res);
      chk({tag, ".ld_c4"}, 32'(rf_ld), 0);
      chk({tag, ".done_c4"}, 32'(done), 0);
      chk({tag, ".ready_c4"}, 32'(instr_ready), 1);
      chk({tag, ".nzp"}, 32'(nzp), 32'(mnzp));
    end
    cmp_regs(tag);
  endtask

  initial begin
    bit          legal;
    logic [15:0] res;
    logic [15:0] r;
    logic [15:0] ins;
    logic [5:0]  low;
    logic [3:0]  op;
    int          dones;
    int          nld;

    rst         = 1'b1;
    scramble    = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0;
    tick;
    tick;
    scramble = 1'b0;
    chk("rst.ready", 32'(instr_ready), 0);
    chk("rst.ld", 32'(rf_ld), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.illegal", 32'(illegal), 0);
    chk("rst.nzp", 32'(nzp), 32'(3'b010));
    chk("rst.dr", 32'(rf_dr), 0);
    chk("rst.sr1", 32'(rf_sr1), 0);
    chk("rst.sr2", 32'(rf_sr2), 0);
    chk("rst.dr_in", 32'(rf_dr_in), 0);
    for (int i = 0; i < 8; i++) mreg[i] = rf[i];
    mnzp = 3'b010;
    rst  = 1'b0;
    tick;
    chk("rel.ready", 32'(instr_ready), 1);

    run(16'h5020, "and_r0_0");
    run(16'h123F, "add_r1_m1");
    run(16'h1441, "add_r2_r1r1");
    run(16'h96BF, "not_r3");
    run(16'h0000, "br_illegal");
    run(16'h96A0, "bad_not");

    // Reset during EXEC aborts the write and forces nzp back to Z.
    instr       = 16'h1261;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    nld = int'(rf_ld);
    tick;
    nld += int'(rf_ld);
    rst = 1'b1;
    tick;
    nld += int'(rf_ld);
    chk("abort.nzp", 32'(nzp), 32'(3'b010));
    chk("abort.ready", 32'(instr_ready), 0);
    chk("abort.done", 32'(done), 0);
    rst = 1'b0;
    tick;
    nld += int'(rf_ld);
    mnzp = 3'b010;
    chk("abort.no_ld", 32'(nld), 0);
    chk("abort.ready_rel", 32'(instr_ready), 1);
    cmp_regs("abort");

    // Producer holds instr_valid; the second ADD must wait for cycle 4.
    dones       = 0;
    instr       = 16'h1042;
    instr_valid = 1'b1;
    model(16'h1042, legal, res);
    tick;
    instr = 16'h1E3F;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("b2b.ready_c%0d", c), 32'(instr_ready), 0);
      chk($sformatf("b2b.done_c%0d", c), 32'(done), 32'(c == 3));
      dones += int'(done);
      tick;
    end
    mreg[0] = res;
    chk("b2b.ready_c4", 32'(instr_ready), 1);
    tick;
    instr_valid = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      chk($sformatf("b2b.done_c%0d", c), 32'(done), 32'(c == 7));
      dones += int'(done);
      tick;
    end
    model(16'h1E3F, legal, res);
    mreg[7] = res;
    mnzp = flags(res);
    chk("b2b.dones", 32'(dones), 2);
    chk("b2b.nzp", 32'(nzp), 32'(mnzp));
    cmp_regs("b2b");

    // Random mix of legal operates and illegal encodings.
    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ins = {4'b0001, r[11:0]};
        1: ins = {4'b0101, r[11:0]};
        2: ins = {4'b1001, r[11:6], 6'h3f};
        default: begin
          if (r[15]) begin
            low = r[5:0];
            if (low == 6'h3f) low = 6'h00;
            ins = {4'b1001, r[11:6], low};
          end else begin
            op = r[15:12];
            if (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) op = 4'b0000;
            ins = {op, r[11:0]};
          end
        end
      endcase
      if (r[13]) tick;
      run(ins, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
